// File: rtl/xbar_sched_pkg.sv
// Shared types for the crossbar priority scheduler: operating modes and config FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package xbar_sched_pkg;

   // Operating modes selectable through the config handshake
   typedef enum logic [1:0] {
      RR_GRANT = 2'd0,
      TSLICE   = 2'd1,
      FIXED    = 2'd2,
      RESERVED = 2'd3
   } mode_e;

   // Config FSM: IDLE accepts requests, PENDING waits for a stall-free cycle to apply
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } cfg_state_e;

endpackage

// File: rtl/xbar_prio_ptr.sv
// Per-target priority pointer: load, wrap-increment from a supplied base, or hold.
// Latency: one cycle from load/step to o_ptr; o_ptr is a plain register.
// Backpressure: none; load always wins over step.
module xbar_prio_ptr #(
   parameter int NumIn    = 4,
   parameter int NumInLog = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                i_load,
   input  logic [NumInLog-1:0] i_load_val,
   input  logic                i_step,
   input  logic [NumInLog-1:0] i_step_base,
   output logic [NumInLog-1:0] o_ptr
);

   localparam logic [NumInLog-1:0] LastIdx = NumInLog'(NumIn - 1);

   logic [NumInLog-1:0] r_ptr;
   logic [NumInLog-1:0] w_load_val;
   logic [NumInLog-1:0] w_step_val;

   // Out-of-range indices collapse to 0 so the pointer always names a real initiator;
   // with a single initiator LastIdx is 0 and both paths always yield 0.
   assign w_load_val = (i_load_val > LastIdx) ? '0 : i_load_val;
   assign w_step_val = (i_step_base >= LastIdx) ? '0 : i_step_base + NumInLog'(1);

   // Pointer register: reset to 0, load has priority over step, otherwise hold
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= w_load_val;
      end else if (i_step) begin
         r_ptr <= w_step_val;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/xbar_prio_scheduler.sv
// Drives per-target external priority (rr_o) to crossbar arbiters in RR_GRANT, TSLICE or FIXED mode.
// Latency: config accepted at t applies at t+1 (earliest), visible at t+2; pointer updates visible next cycle.
// Backpressure: cfg_ready_o drops while a config is pending; apply is deferred while any target stalls.
module xbar_prio_scheduler
   import xbar_sched_pkg::*;
#(
   parameter  int NumIn    = 4,
   parameter  int NumOut   = 4,
   parameter  int SliceLen = 8,
   localparam int NumInLog = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cfg_valid_i,
   output logic                              cfg_ready_o,
   input  logic [1:0]                        cfg_mode_i,
   input  logic [NumInLog-1:0]               cfg_prio_i,
   input  logic [NumOut-1:0]                 hs_valid_i,
   input  logic [NumOut-1:0]                 hs_ready_i,
   input  logic [NumOut-1:0][NumInLog-1:0]   hs_ini_addr_i,
   output logic [NumOut-1:0][NumInLog-1:0]   rr_o,
   output logic [1:0]                        mode_o,
   output logic                              cfg_err_o
);

   localparam int                SliceW    = (SliceLen <= 1) ? 1 : $clog2(SliceLen);
   localparam logic [SliceW-1:0] SliceLast = SliceW'(SliceLen - 1);

   if (NumIn == 0 || NumOut == 0 || SliceLen == 0) begin : g_bad_param
      $fatal(1, "xbar_prio_scheduler: NumIn, NumOut and SliceLen must all be >= 1");
   end

   cfg_state_e          r_state;
   mode_e               r_mode;
   mode_e               r_shadow_mode;
   logic [NumInLog-1:0] r_shadow_prio;
   logic [SliceW-1:0]   r_slice_cnt;
   logic                r_cfg_ready;
   logic                r_cfg_err;

   logic [NumOut-1:0]   w_hs;
   logic                w_stall;
   logic                w_apply;
   logic                w_slice_roll;
   logic [NumInLog-1:0] w_load_val;

   assign w_hs         = hs_valid_i & hs_ready_i;
   assign w_stall      = |(hs_valid_i & ~hs_ready_i);
   // Switching arbitration policy mid-stall could starve the stalled beat, so wait it out.
   assign w_apply      = (r_state == ST_PENDING) && !w_stall;
   assign w_slice_roll = (r_mode == TSLICE) && (r_slice_cnt == SliceLast);
   assign w_load_val   = (r_shadow_mode == FIXED) ? r_shadow_prio : '0;

   // Config FSM: shadow the request, apply it in the first stall-free cycle, flag reserved modes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_cfg_ready   <= 1'b1;
         r_cfg_err     <= 1'b0;
         r_mode        <= RR_GRANT;
         r_shadow_mode <= RR_GRANT;
         r_shadow_prio <= '0;
      end else begin
         r_cfg_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_valid_i) begin
                  if (cfg_mode_i == 2'(RESERVED)) begin
                     // Accepted but otherwise ignored; only the error pulse results
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_shadow_mode <= mode_e'(cfg_mode_i);
                     r_shadow_prio <= cfg_prio_i;
                     r_state       <= ST_PENDING;
                     r_cfg_ready   <= 1'b0;
                  end
               end
            end
            ST_PENDING: begin
               if (!w_stall) begin
                  r_mode      <= r_shadow_mode;
                  r_state     <= ST_IDLE;
                  r_cfg_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   // Time-slice counter: runs only in TSLICE, restarts on every config apply
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_slice_cnt <= '0;
      end else if (w_apply) begin
         r_slice_cnt <= '0;
      end else if (r_mode == TSLICE) begin
         r_slice_cnt <= w_slice_roll ? '0 : r_slice_cnt + SliceW'(1);
      end
   end

   // One pointer per target; apply drives load, which the pointer ranks above any step
   for (genvar k = 0; k < NumOut; k++) begin : g_ptr
      logic                w_step;
      logic [NumInLog-1:0] w_step_base;
      logic [NumInLog-1:0] w_ptr;

      assign w_step      = (r_mode == TSLICE)   ? w_slice_roll :
                           (r_mode == RR_GRANT) ? w_hs[k]      : 1'b0;
      assign w_step_base = (r_mode == TSLICE) ? w_ptr : hs_ini_addr_i[k];

      xbar_prio_ptr #(
         .NumIn    (NumIn),
         .NumInLog (NumInLog)
      ) u_ptr (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .i_load      (w_apply),
         .i_load_val  (w_load_val),
         .i_step      (w_step),
         .i_step_base (w_step_base),
         .o_ptr       (w_ptr)
      );

      assign rr_o[k] = w_ptr;
   end

   assign cfg_ready_o = r_cfg_ready;
   assign cfg_err_o   = r_cfg_err;
   assign mode_o      = r_mode;

endmodule

// File: tb/tb_xbar_prio_scheduler.sv
// Directed bench for xbar_prio_scheduler (NumIn=4, NumOut=2, SliceLen=3).
// Latency: expectations are queued before each clock edge and compared #1 after it.
// Backpressure: stalls are driven on hs_valid_i/hs_ready_i to exercise deferred apply.
module tb_xbar_prio_scheduler;

   localparam int NumIn    = 4;
   localparam int NumOut   = 2;
   localparam int SliceLen = 3;
   localparam int NumInLog = 2;

   logic                            clk = 1'b0;
   logic                            rst;
   logic                            cfg_valid;
   logic                            cfg_ready;
   logic [1:0]                      cfg_mode;
   logic [NumInLog-1:0]             cfg_prio;
   logic [NumOut-1:0]               hs_valid;
   logic [NumOut-1:0]               hs_ready;
   logic [NumOut-1:0][NumInLog-1:0] hs_ini_addr;
   logic [NumOut-1:0][NumInLog-1:0] rr;
   logic [1:0]                      mode;
   logic                            cfg_err;

   always #5 clk = ~clk;

   xbar_prio_scheduler #(
      .NumIn    (NumIn),
      .NumOut   (NumOut),
      .SliceLen (SliceLen)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cfg_valid_i   (cfg_valid),
      .cfg_ready_o   (cfg_ready),
      .cfg_mode_i    (cfg_mode),
      .cfg_prio_i    (cfg_prio),
      .hs_valid_i    (hs_valid),
      .hs_ready_i    (hs_ready),
      .hs_ini_addr_i (hs_ini_addr),
      .rr_o          (rr),
      .mode_o        (mode),
      .cfg_err_o     (cfg_err)
   );

   typedef struct packed {
      logic [1:0] rr0;
      logic [1:0] rr1;
      logic [1:0] mode;
      logic       rdy;
      logic       err;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic expect_out(input string tag, input logic [1:0] r0, input logic [1:0] r1,
                             input logic [1:0] m, input logic rdy, input logic err);
      obs_t e;
      e.rr0  = r0;
      e.rr1  = r1;
      e.mode = m;
      e.rdy  = rdy;
      e.err  = err;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_out();
      obs_t  e;
      obs_t  o;
      string t;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed no queued expectation, expected one");
         return;
      end
      e      = exp_q.pop_front();
      t      = tag_q.pop_front();
      o.rr0  = rr[0];
      o.rr1  = rr[1];
      o.mode = mode;
      o.rdy  = cfg_ready;
      o.err  = cfg_err;
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed rr={%0d,%0d} mode=%0d rdy=%0b err=%0b, expected rr={%0d,%0d} mode=%0d rdy=%0b err=%0b",
                t, o.rr0, o.rr1, o.mode, o.rdy, o.err, e.rr0, e.rr1, e.mode, e.rdy, e.err);
      end
   endtask

   // Queue the expectation for the coming edge, clock once, then compare
   task automatic cyc(input string tag, input logic [1:0] r0, input logic [1:0] r1,
                      input logic [1:0] m, input logic rdy, input logic err);
      expect_out(tag, r0, r1, m, rdy, err);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      logic [1:0] p;

      rst         = 1'b1;
      cfg_valid   = 1'b0;
      cfg_mode    = 2'd0;
      cfg_prio    = '0;
      hs_valid    = '0;
      hs_ready    = '0;
      hs_ini_addr = '0;

      // Reset held two cycles
      cyc("reset_1", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
      cyc("reset_2", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
      rst = 1'b0;
      cyc("idle", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

      // RR_GRANT: pointer = granted index + 1, wrapping 3 -> 0
      hs_valid = 2'b11; hs_ready = 2'b11;
      hs_ini_addr[0] = 2'd2; hs_ini_addr[1] = 2'd1;
      cyc("rr_inc", 2'd3, 2'd2, 2'd0, 1'b1, 1'b0);
      hs_valid = 2'b10; hs_ready = 2'b10;
      hs_ini_addr[0] = 2'd0; hs_ini_addr[1] = 2'd3;
      cyc("rr_wrap", 2'd3, 2'd0, 2'd0, 1'b1, 1'b0);
      hs_valid = 2'b01; hs_ready = 2'b00;
      cyc("rr_hold_no_hs", 2'd3, 2'd0, 2'd0, 1'b1, 1'b0);

      // Collision: apply of mode 0 beats a same-cycle handshake
      hs_valid = 2'b00; hs_ready = 2'b00;
      cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_prio = 2'd3;
      cyc("collide_accept", 2'd3, 2'd0, 2'd0, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      hs_valid = 2'b11; hs_ready = 2'b11;
      hs_ini_addr[0] = 2'd1; hs_ini_addr[1] = 2'd1;
      cyc("collide_apply", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

      // Deferred apply: FIXED prio 2 held back while target 0 stalls 5 cycles
      hs_valid = 2'b01; hs_ready = 2'b00;
      cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_prio = 2'd2;
      cyc("defer_accept", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      cyc("defer_stall_2", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      hs_valid = 2'b11; hs_ready = 2'b10; hs_ini_addr[1] = 2'd2;
      cyc("defer_stall_3_rr_t1", 2'd0, 2'd3, 2'd0, 1'b0, 1'b0);
      hs_valid = 2'b01; hs_ready = 2'b00;
      cyc("defer_stall_4", 2'd0, 2'd3, 2'd0, 1'b0, 1'b0);
      cyc("defer_stall_5", 2'd0, 2'd3, 2'd0, 1'b0, 1'b0);
      hs_valid = 2'b00;
      cyc("defer_apply", 2'd2, 2'd2, 2'd2, 1'b1, 1'b0);

      // FIXED ignores handshakes
      hs_valid = 2'b11; hs_ready = 2'b11;
      hs_ini_addr[0] = 2'd0; hs_ini_addr[1] = 2'd3;
      cyc("fixed_hold_1", 2'd2, 2'd2, 2'd2, 1'b1, 1'b0);
      cyc("fixed_hold_2", 2'd2, 2'd2, 2'd2, 1'b1, 1'b0);
      hs_valid = 2'b00; hs_ready = 2'b00;

      // Reserved mode: accepted, single-cycle error pulse, no state change
      cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_prio = 2'd1;
      cyc("reserved_accept", 2'd2, 2'd2, 2'd2, 1'b1, 1'b1);
      cfg_valid = 1'b0;
      cyc("reserved_pulse_end", 2'd2, 2'd2, 2'd2, 1'b1, 1'b0);
      cyc("reserved_still_idle", 2'd2, 2'd2, 2'd2, 1'b1, 1'b0);

      // TSLICE: both pointers rotate every SliceLen cycles; handshakes ignored
      cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_prio = 2'd3;
      cyc("tslice_accept", 2'd2, 2'd2, 2'd2, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      cyc("tslice_apply", 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         if (i == 4) begin
            hs_valid = 2'b11; hs_ready = 2'b11;
            hs_ini_addr[0] = 2'd1; hs_ini_addr[1] = 2'd2;
         end else begin
            hs_valid = 2'b00; hs_ready = 2'b00;
         end
         p = 2'(((i + 1) / SliceLen) % NumIn);
         cyc($sformatf("tslice_%0d", i), p, p, 2'd1, 1'b1, 1'b0);
      end

      // Reset during PENDING discards the shadow config
      hs_valid = 2'b01; hs_ready = 2'b00;
      cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_prio = 2'd3;
      cyc("rstpend_accept", 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
      cfg_valid = 1'b0;
      rst = 1'b1;
      cyc("rstpend_reset", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
      rst = 1'b0;
      hs_valid = 2'b00;
      cyc("rstpend_no_apply_1", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
      cyc("rstpend_no_apply_2", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
